// File: rtl/clk_div_gen.sv
// ---------------------------------------------------------------------------
// clk_div_gen
// Multi-channel clock-enable generator. Each channel divides clk by a run-time
// programmable ratio and produces a registered divided-clock level (clk_out)
// and a registered one-cycle strobe (tick) at the end of every period.
// New divisors are posted through a valid/ready port. They take effect only
// on the channel's next period boundary, so the outputs never glitch.
//
// Parameters:
//   WIDTH       divisor/counter width
//   N_CH        number of channels (1..16)
//   DEFAULT_DIV divisor loaded into every channel at reset (>= 2)
//   CW          channel-select width, $clog2(N_CH) with a minimum of 1
//
// Ports:
//   clk          rising-edge clock
//   reset        synchronous active-high reset
//   en           global count enable; low freezes counters and clk_out
//   ld_valid     divisor load request
//   ld_ch        target channel of the load
//   ld_div       requested divisor (0 and 1 are clamped to 2)
//   ld_ready     load can be accepted this cycle (combinational)
//   clk_out      divided-clock level per channel
//   tick         one-cycle pulse per channel period
//   sync_restart phase-aligns all channels (only with CLKDIV_SYNC_RESTART_EN)
//
// Optional feature macro: CLKDIV_SYNC_RESTART_EN
// ---------------------------------------------------------------------------
module clk_div_gen #(
   parameter int WIDTH       = 18,
   parameter int N_CH        = 2,
   parameter int DEFAULT_DIV = 2,
   parameter int CW          = (N_CH > 1) ? $clog2(N_CH) : 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             ld_valid,
   input  logic [CW-1:0]    ld_ch,
   input  logic [WIDTH-1:0] ld_div,
   output logic             ld_ready,
   output logic [N_CH-1:0]  clk_out,
`ifdef CLKDIV_SYNC_RESTART_EN
   output logic [N_CH-1:0]  tick,
   input  logic             sync_restart
`else
   output logic [N_CH-1:0]  tick
`endif
);

   // Per-channel state
   logic [WIDTH-1:0] cnt_r      [N_CH];
   logic [WIDTH-1:0] div_r      [N_CH];
   logic [WIDTH-1:0] pend_div_r [N_CH];
   logic [N_CH-1:0]  pend_r;
   logic [N_CH-1:0]  clk_out_r;
   logic [N_CH-1:0]  tick_r;

   // Next-state helpers
   logic [WIDTH-1:0] cnt_next_s [N_CH];
   logic [N_CH-1:0]  wrap_s;
   logic [N_CH-1:0]  hi_next_s;
   logic [N_CH-1:0]  ld_sel_s;
   logic             ld_ready_s;
   logic             accept_s;
   logic [WIDTH-1:0] ld_div_clamped_s;

   // Load decode: an out-of-range ld_ch matches no channel, so it is never ready
   always_comb begin
      ld_ready_s = 1'b0;
      ld_sel_s   = {N_CH{1'b0}};
      for (int i = 0; i < N_CH; i++) begin
         ld_sel_s[i] = (ld_ch == CW'(i));
         ld_ready_s  = ld_ready_s | (ld_sel_s[i] & ~pend_r[i]);
      end
      accept_s         = ld_valid & ld_ready_s;
      ld_div_clamped_s = (ld_div < WIDTH'(2)) ? WIDTH'(2) : ld_div;
   end

   // Period arithmetic: wrap detection, next count and next output level
   always_comb begin
      for (int i = 0; i < N_CH; i++) begin
         wrap_s[i]     = (cnt_r[i] == (div_r[i] - WIDTH'(1)));
         cnt_next_s[i] = wrap_s[i] ? {WIDTH{1'b0}} : (cnt_r[i] + WIDTH'(1));
         // Level is high in the upper half of the period; for odd divisors the
         // high phase gets the extra cycle.
         hi_next_s[i]  = (cnt_next_s[i] >= (div_r[i] >> 1));
      end
   end

   // Channel state update: reset > sync_restart > en; loads land last
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < N_CH; i++) begin
            cnt_r[i]      <= {WIDTH{1'b0}};
            div_r[i]      <= WIDTH'(DEFAULT_DIV);
            pend_div_r[i] <= WIDTH'(DEFAULT_DIV);
            pend_r[i]     <= 1'b0;
            clk_out_r[i]  <= 1'b0;
            tick_r[i]     <= 1'b0;
         end
      end else begin
         for (int i = 0; i < N_CH; i++) begin
`ifdef CLKDIV_SYNC_RESTART_EN
            if (sync_restart) begin
               cnt_r[i]     <= {WIDTH{1'b0}};
               clk_out_r[i] <= 1'b0;
               tick_r[i]    <= 1'b0;
               if (pend_r[i]) begin
                  div_r[i]  <= pend_div_r[i];
                  pend_r[i] <= 1'b0;
               end else begin
                  div_r[i]  <= div_r[i];
               end
            end else
`endif
            if (en) begin
               cnt_r[i]     <= cnt_next_s[i];
               clk_out_r[i] <= hi_next_s[i];
               tick_r[i]    <= wrap_s[i];
               // A pending divisor only switches in on a period boundary
               if (wrap_s[i] && pend_r[i]) begin
                  div_r[i]  <= pend_div_r[i];
                  pend_r[i] <= 1'b0;
               end else begin
                  div_r[i]  <= div_r[i];
               end
            end else begin
               tick_r[i] <= 1'b0;
            end
            // Accept requires pend=0, so this never collides with an apply
            // above; a load coinciding with a wrap waits for the next wrap.
            if (accept_s && ld_sel_s[i]) begin
               pend_div_r[i] <= ld_div_clamped_s;
               pend_r[i]     <= 1'b1;
            end else begin
               pend_div_r[i] <= pend_div_r[i];
            end
         end
      end
   end

   assign ld_ready = ld_ready_s;
   assign clk_out  = clk_out_r;
   assign tick     = tick_r;

endmodule

// File: tb/tb_clk_div_gen.sv
// ---------------------------------------------------------------------------
// tb_clk_div_gen
// Directed plus randomized stimulus for clk_div_gen. Three channels are used
// so that an out-of-range ld_ch exists. Every cycle is compared against a
// period/phase reference model.
// ---------------------------------------------------------------------------
module tb_clk_div_gen;

   localparam int N  = 3;
   localparam int W  = 18;
   localparam int DD = 2;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          en = 1'b0;
   logic          ld_valid = 1'b0;
   logic [1:0]    ld_ch = 2'd0;
   logic [W-1:0]  ld_div = '0;
   logic          ld_ready;
   logic [N-1:0]  clk_out;
   logic [N-1:0]  tick;
   logic          sync_restart = 1'b0;

   int checks = 0;
   int errors = 0;

   // Reference model: phase within the period, divisor, pending load
   int m_ph    [N];
   int m_div   [N];
   int m_pdiv  [N];
   bit m_pend  [N];
   bit m_clk   [N];
   bit m_tick  [N];

   clk_div_gen #(.WIDTH(W), .N_CH(N), .DEFAULT_DIV(DD)) dut (
      .clk      (clk),
      .reset    (reset),
      .en       (en),
      .ld_valid (ld_valid),
      .ld_ch    (ld_ch),
      .ld_div   (ld_div),
      .ld_ready (ld_ready),
      .clk_out  (clk_out),
`ifdef CLKDIV_SYNC_RESTART_EN
      .tick     (tick),
      .sync_restart (sync_restart)
`else
      .tick     (tick)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic bit model_ready();
      if (int'(ld_ch) < N) return !m_pend[ld_ch];
      return 1'b0;
   endfunction

   // Advance the model by one clock edge using the current inputs
   task automatic model_edge(input bit acc);
      int d;
      if (reset) begin
         for (int c = 0; c < N; c++) begin
            m_ph[c] = 0; m_div[c] = DD; m_pend[c] = 0;
            m_clk[c] = 0; m_tick[c] = 0;
         end
      end else begin
         for (int c = 0; c < N; c++) begin
            d = m_div[c];
            if (sync_restart) begin
               m_ph[c] = 0; m_clk[c] = 0; m_tick[c] = 0;
               if (m_pend[c]) begin m_div[c] = m_pdiv[c]; m_pend[c] = 0; end
            end else if (en) begin
               m_tick[c] = (m_ph[c] == d - 1);
               m_ph[c]   = (m_ph[c] + 1) % d;
               m_clk[c]  = (m_ph[c] >= d / 2);
               if (m_tick[c] && m_pend[c]) begin m_div[c] = m_pdiv[c]; m_pend[c] = 0; end
            end else begin
               m_tick[c] = 0;
            end
         end
         if (acc) begin
            m_pdiv[ld_ch] = (int'(ld_div) < 2) ? 2 : int'(ld_div);
            m_pend[ld_ch] = 1;
         end
      end
   endtask

   // One clock cycle: check ld_ready, clock, then check outputs
   task automatic step();
      bit rdy;
      logic [N-1:0] ec, et;
      #1;
      rdy = model_ready();
      check("ld_ready", {31'd0, ld_ready}, {31'd0, rdy});
      @(posedge clk);
      model_edge(ld_valid && rdy);
      #1;
      for (int c = 0; c < N; c++) begin ec[c] = m_clk[c]; et[c] = m_tick[c]; end
      check("clk_out", {29'd0, clk_out}, {29'd0, ec});
      check("tick", {29'd0, tick}, {29'd0, et});
   endtask

   task automatic load(input int ch, input int dv);
      ld_valid = 1'b1; ld_ch = 2'(ch); ld_div = W'(dv);
      step();
      ld_valid = 1'b0;
   endtask

   logic [3:0] seq_clk, seq_tick;
   int ones, nticks, both;

   initial begin
      for (int c = 0; c < N; c++) begin
         m_ph[c] = 0; m_div[c] = DD; m_pend[c] = 0; m_pdiv[c] = DD;
         m_clk[c] = 0; m_tick[c] = 0;
      end
      @(posedge clk); #1;

      // Reset state
      reset = 1'b1; step(); step();
      check("reset_clk_out", {29'd0, clk_out}, 32'd0);
      check("reset_tick", {29'd0, tick}, 32'd0);

      // Legacy divide-by-2 behaviour
      reset = 1'b0; en = 1'b1;
      for (int k = 0; k < 4; k++) begin
         step();
         seq_clk[k] = clk_out[0]; seq_tick[k] = tick[0];
      end
      check("div2_clk_seq", {28'd0, seq_clk}, 32'h5);
      check("div2_tick_seq", {28'd0, seq_tick}, 32'ha);

      // Go to div=4, then load 5 at phase 0 of a div=4 period
      load(0, 4);
      for (int k = 0; k < 20 && m_pend[0]; k++) step();
      check("apply4_timeout", {31'd0, m_pend[0]}, 32'd0);
      for (int k = 0; k < 8 && m_ph[0] != 0; k++) step();
      load(0, 5);
      check("pend_ready_low", {31'd0, ld_ready}, 32'd0);
      for (int k = 0; k < 20 && m_pend[0]; k++) step();
      check("apply5_timeout", {31'd0, m_pend[0]}, 32'd0);
      ones = 0; nticks = 0;
      for (int k = 0; k < 10; k++) begin
         step();
         ones += int'(clk_out[0]); nticks += int'(tick[0]);
      end
      check("div5_high_cycles", ones, 32'd6);
      check("div5_ticks", nticks, 32'd2);

      // Clamp of 0 and out-of-range channel
      load(1, 7);
      for (int k = 0; k < 20 && m_pend[1]; k++) step();
      load(1, 0);
      for (int k = 0; k < 20 && m_pend[1]; k++) step();
      load(3, 9);
      step();

      // Second load to a pending channel is refused; another channel accepts
      load(2, 7);
      load(2, 3);
      load(0, 4);
      for (int k = 0; k < 20; k++) step();

      // Freeze for 7 cycles mid-period
      step(); step();
      en = 1'b0;
      for (int k = 0; k < 7; k++) step();
      en = 1'b1;
      for (int k = 0; k < 10; k++) step();

`ifdef CLKDIV_SYNC_RESTART_EN
      load(0, 3);
      load(1, 6);
      for (int k = 0; k < 20; k++) step();
      sync_restart = 1'b1; step(); sync_restart = 1'b0;
      both = 0;
      for (int k = 0; k < 12; k++) begin
         step();
         both += int'(tick[0] & tick[1]);
      end
      check("restart_coincide", both, 32'd2);
`endif

      // Randomized traffic
      for (int k = 0; k < 600; k++) begin
         reset    = ($urandom_range(0, 149) == 0);
         en       = ($urandom_range(0, 5) != 0);
         ld_valid = ($urandom_range(0, 2) == 0);
         ld_ch    = 2'($urandom_range(0, 3));
         ld_div   = W'($urandom_range(0, 9));
`ifdef CLKDIV_SYNC_RESTART_EN
         sync_restart = ($urandom_range(0, 59) == 0);
`endif
         step();
      end
      reset = 1'b0; ld_valid = 1'b0; sync_restart = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/clk_div_gen.md
# clk_div_gen

Parametrised multi-channel clock-enable generator, the successor to the fixed divide-by-2 toggle divider. Each of `N_CH` channels divides `clk` by a run-time programmable integer ratio and produces a divided-clock level and a one-cycle tick. New ratios are loaded through a valid/ready port and applied only at a period boundary, so the outputs never glitch. The block sits next to the top-level clock input and feeds display-scan, debounce and baud-rate logic with strobes that stay in the `clk` domain.

## Interface
- `WIDTH`, 18: divisor/counter width in bits.
- `N_CH`, 2: number of independent channels, 1..16.
- `DEFAULT_DIV`, 2: divisor loaded into every channel at reset. Must be ≥2.
- `CW`, derived: `$clog2(N_CH)`, with a minimum of 1.

- `clk`  in  1  single clock; everything is on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `en`  in  1  global count enable; low freezes all counters and outputs.
- `ld_valid`  in  1  load request.
- `ld_ch`  in  CW  target channel.
- `ld_div`  in  WIDTH  requested divisor; values 0 and 1 are clamped to 2.
- `ld_ready`  out  1  load can be accepted this cycle.
- `clk_out`  out  N_CH  divided-clock level per channel, registered.
- `tick`  out  N_CH  one-cycle pulse per channel period, registered.
- `sync_restart`  in  1  present only with `CLKDIV_SYNC_RESTART_EN`.

## Operation
- Per-channel state:
  - `cnt` (WIDTH bits)
  - `div` (WIDTH bits)
  - `pend_div` (WIDTH bits)
  - `pend` (1 bit)
- Priority on each edge: `reset` > `sync_restart` > `en`.
- Reset state:
  - `cnt`=0, `div`=`DEFAULT_DIV`, `pend`=0.
  - `clk_out`=0, `tick`=0.
- On an edge with `en`=1, for each channel:
  - `wrap` = (`cnt` == `div`-1).
  - `cnt_next` = `wrap` ? 0 : `cnt`+1.
  - `clk_out` <= (`cnt_next` ≥ floor(`div`/2)).
  - `tick` <= `wrap`.
  - If `wrap` and `pend`: `div` <= `pend_div`, `pend` <= 0.
- On an edge with `en`=0:
  - `cnt` and `clk_out` hold.
  - `tick` <= 0.
  - Pending loads are not applied.
- Duty cycle:
  - Even `div`: exactly 50%.
  - Odd `div`: high for ceil(`div`/2) cycles, low for floor(`div`/2) cycles.
  - `div`=2 reproduces the legacy toggle, with `clk_out` = 1 after the first enabled edge.
- Load handshake:
  - `ld_ready` = (`ld_ch` < `N_CH`) && !`pend[ld_ch]`. This is combinational from the registers and `ld_ch`.
  - Accept condition: `ld_valid` && `ld_ready`.
  - On accept: `pend_div[ld_ch]` <= max(`ld_div`, 2) and `pend[ld_ch]` <= 1.
  - An out-of-range `ld_ch` is never accepted.
- Simultaneous load and wrap on the same channel, with `pend`=0: the load is accepted and applied at the *next* wrap, not the current one.
- Reset during a pending load: the pending value is discarded and `div` returns to `DEFAULT_DIV`.
- All arithmetic is unsigned, WIDTH bits. The maximum period is 2^WIDTH-1 cycles.

## Timing
- Load-to-effect latency: from acceptance to the channel's next enabled wrap edge. The worst case is `div` enabled cycles.
- `ld_ready` for the loaded channel:
  - Goes low the cycle after acceptance.
  - Goes high again the cycle after the applying wrap.
- `tick` rises on the same edge where `clk_out` falls to 0.
- Every channel runs independently. Channels share only `en` and `sync_restart`.

## Configuration
- `CLKDIV_SYNC_RESTART_EN` defined:
  - Adds the input `sync_restart`.
  - On an edge with `sync_restart`=1 (regardless of `en`), every channel gets: `cnt`=0, `clk_out`=0, `tick`=0.
  - Any pending divisor is applied immediately, with `pend`=0.
  - Effect: all channels become phase-aligned.
- Undefined: the port is absent and there is no restart logic.

## Test plan
- Reset with `DEFAULT_DIV`=2, `en`=1 → `clk_out[0]` = 1,0,1,0 on edges 1–4 after reset. `tick[0]` = 1 on edges 2 and 4.
- Load ch0 `div`=5 at cnt=0 of a `div`=4 period → old period completes. Then `clk_out` shows 3 high and 2 low per period, with `tick` every 5 cycles. `ld_ready` is low from the accept edge+1 until the apply edge+1.
- Load `ld_div`=0 → effective divisor is 2. A load with `ld_ch`=`N_CH` sees `ld_ready`=0 and leaves all channels unchanged.
- Second load to a channel with `pend`=1 → `ld_ready`=0 and the request is not accepted. A load on ch1 in the same period is accepted.
- `en` low for 7 cycles mid-period → `cnt`/`clk_out` frozen and `tick`=0 throughout. The period resumes exactly where it stopped.
- (`CLKDIV_SYNC_RESTART_EN`) ch0 `div`=3 and ch1 `div`=6 at arbitrary phases, then pulse `sync_restart` → both reach `cnt`=0 on the same edge. Both `tick`s then coincide every 6 cycles.
